// File: rtl/stage_if.sv
// stage_if -- Instruction Fetch stage with the IF/ID pipeline register.
//
// Owns the PC. Fetches one word per request from a variable-latency
// instruction memory. Presents the fetched instruction to Decode through
// the IF/ID register. Honours a load-use stall, a jump redirect from ID
// and a taken-branch redirect from EX.
//
// Ports:
//   Clk, Rst_n          clock (rising edge), asynchronous active-low reset
//   Stall               hold PC and IF/ID
//   Jump, Jtarg         jump redirect and its target
//   BrTaken, Btarg      taken-branch redirect and its target (wins over Jump)
//   IM_Req, IM_Addr     fetch request and word-aligned fetch address
//   IM_Ready, IM_Data   request completion and the fetched word
//   IFout_PC/PC4/Inst   IF/ID contents; all zero for a bubble
//   IFout_Valid         IF/ID holds a real instruction
//   Dbg_State           current FSM state (S_REQ=0, S_HOLD=1, S_DROP=2)
//
// Optional feature, enabled by defining STAGE_IF_PERF_EN:
//   Perf_Fetch   Ready transfers whose data enters IF/ID or the hold buffer
//   Perf_Bubble  cycles in which IF/ID is loaded with a bubble
//
// Handshake: a transfer completes in any cycle where IM_Req && IM_Ready.
// Once IM_Req is raised, IM_Req and IM_Addr stay stable until IM_Ready.
module stage_if #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Stall,
  input  logic        Jump,
  input  logic [31:0] Jtarg,
  input  logic        BrTaken,
  input  logic [31:0] Btarg,
  output logic        IM_Req,
  output logic [31:0] IM_Addr,
  input  logic        IM_Ready,
  input  logic [31:0] IM_Data,
  output logic [31:0] IFout_PC,
  output logic [31:0] IFout_PC4,
  output logic [31:0] IFout_Inst,
  output logic        IFout_Valid,
  output logic [1:0]  Dbg_State
`ifdef STAGE_IF_PERF_EN
  ,
  output logic [31:0] Perf_Fetch,
  output logic [31:0] Perf_Bubble
`endif
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_HOLD = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] drop_addr_q, drop_addr_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic [31:0] hold_inst_q, hold_inst_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_pc4_q, if_pc4_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic        if_valid_q, if_valid_d;
  // Keeps IM_Req low between reset release and the first clock edge.
  logic        req_en_q;

  logic        redirect;
  logic [31:0] target;
  logic        xfer;
  logic [31:0] pc_plus4;
  logic        load_bubble;

  assign redirect = BrTaken || Jump;
  // Branch is the older instruction, so it wins; low bits are dropped.
  assign target   = (BrTaken ? Btarg : Jtarg) & 32'hFFFF_FFFC;
  assign xfer     = IM_Req && IM_Ready;
  assign pc_plus4 = pc_q + 32'd4;

  assign IM_Req      = req_en_q && (state_q != S_HOLD);
  // In S_DROP the in-flight request keeps its original address even though
  // PC already points at the redirect target.
  assign IM_Addr     = (state_q == S_DROP) ? drop_addr_q : pc_q;
  assign IFout_PC    = if_pc_q;
  assign IFout_PC4   = if_pc4_q;
  assign IFout_Inst  = if_inst_q;
  assign IFout_Valid = if_valid_q;
  assign Dbg_State   = state_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_addr_d = drop_addr_q;
    hold_pc_d   = hold_pc_q;
    hold_inst_d = hold_inst_q;
    if_pc_d     = if_pc_q;
    if_pc4_d    = if_pc4_q;
    if_inst_d   = if_inst_q;
    if_valid_d  = if_valid_q;
    load_bubble = 1'b0;

    case (state_q)
      S_REQ: begin
        if (redirect) begin
          pc_d        = target;
          load_bubble = 1'b1;
          if (!xfer) begin
            // Request still outstanding: finish it before fetching the target.
            state_d     = S_DROP;
            drop_addr_d = pc_q;
          end
        end else if (xfer && !Stall) begin
          if_pc_d    = pc_q;
          if_pc4_d   = pc_plus4;
          if_inst_d  = IM_Data;
          if_valid_d = 1'b1;
          pc_d       = pc_plus4;
        end else if (xfer) begin
          // Data arrived while Decode is stalled: park it.
          hold_pc_d   = pc_q;
          hold_inst_d = IM_Data;
          state_d     = S_HOLD;
        end else if (!Stall) begin
          load_bubble = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          pc_d        = target;
          load_bubble = 1'b1;
          state_d     = S_REQ;
        end else if (!Stall) begin
          if_pc_d    = hold_pc_q;
          if_pc4_d   = hold_pc_q + 32'd4;
          if_inst_d  = hold_inst_q;
          if_valid_d = 1'b1;
          pc_d       = pc_plus4;
          state_d    = S_REQ;
        end
      end
      S_DROP: begin
        if (redirect) begin
          pc_d        = target;
          load_bubble = 1'b1;
        end else if (!Stall) begin
          load_bubble = 1'b1;
        end
        if (xfer) begin
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase

    if (load_bubble) begin
      if_pc_d    = 32'h0;
      if_pc4_d   = 32'h0;
      if_inst_d  = 32'h0;
      if_valid_d = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC & 32'hFFFF_FFFC;
      drop_addr_q <= 32'h0;
      hold_pc_q   <= 32'h0;
      hold_inst_q <= 32'h0;
      if_pc_q     <= 32'h0;
      if_pc4_q    <= 32'h0;
      if_inst_q   <= 32'h0;
      if_valid_q  <= 1'b0;
      req_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_addr_q <= drop_addr_d;
      hold_pc_q   <= hold_pc_d;
      hold_inst_q <= hold_inst_d;
      if_pc_q     <= if_pc_d;
      if_pc4_q    <= if_pc4_d;
      if_inst_q   <= if_inst_d;
      if_valid_q  <= if_valid_d;
      req_en_q    <= 1'b1;
    end
  end

`ifdef STAGE_IF_PERF_EN
  // Only S_REQ transfers without a redirect deliver useful data.
  logic fetch_used;
  assign fetch_used = xfer && (state_q == S_REQ) && !redirect;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Perf_Fetch  <= 32'h0;
      Perf_Bubble <= 32'h0;
    end else begin
      if (fetch_used) begin
        Perf_Fetch <= Perf_Fetch + 32'd1;
      end
      if (load_bubble) begin
        Perf_Bubble <= Perf_Bubble + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_stage_if.sv
// tb_stage_if -- self-checking bench for stage_if.
// Driver issues stimulus and pushes expected IF/ID deliveries into exp_q;
// a negedge monitor pops and compares whenever an instruction is presented.
module tb_stage_if;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        Stall = 1'b0;
  logic        Jump = 1'b0;
  logic [31:0] Jtarg = 32'h0;
  logic        BrTaken = 1'b0;
  logic [31:0] Btarg = 32'h0;
  logic        IM_Ready = 1'b0;
  logic [31:0] IM_Data = 32'h0;
  logic        IM_Req;
  logic [31:0] IM_Addr;
  logic [31:0] IFout_PC, IFout_PC4, IFout_Inst;
  logic        IFout_Valid;
  logic [1:0]  Dbg_State;

  stage_if #(.RESET_PC(RESET_PC)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Stall(Stall), .Jump(Jump), .Jtarg(Jtarg),
    .BrTaken(BrTaken), .Btarg(Btarg), .IM_Req(IM_Req), .IM_Addr(IM_Addr),
    .IM_Ready(IM_Ready), .IM_Data(IM_Data), .IFout_PC(IFout_PC),
    .IFout_PC4(IFout_PC4), .IFout_Inst(IFout_Inst), .IFout_Valid(IFout_Valid),
    .Dbg_State(Dbg_State)
  );

  // ---------------- clock / cycle count ----------------
  always #5 Clk = ~Clk;
  logic [31:0] cyc = 32'h0;
  always @(posedge Clk) cyc <= cyc + 32'd1;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail = 0;
  // entry = {due cycle, pc, inst}; due = all-ones while parked in the hold buffer
  logic [95:0] exp_q[$];
  logic [31:0] model_pc = RESET_PC;
  logic        buffered = 1'b0;
  logic        stale = 1'b0;
  logic [31:0] stale_addr = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic st, input logic jp, input logic [31:0] jt,
                      input logic br, input logic [31:0] bt, input logic rdy);
    logic        req, xfer, redir;
    logic [31:0] addr, tgt;
    logic [95:0] e;
    @(posedge Clk);
    #1;
    req  = IM_Req;
    addr = IM_Addr;
    check("im_req", {31'h0, req}, {31'h0, !buffered});
    if (req) check("im_addr", addr, stale ? stale_addr : model_pc);
    Stall = st; Jump = jp; Jtarg = jt; BrTaken = br; Btarg = bt; IM_Ready = rdy;
    IM_Data = rdy ? mem_word(addr) : $urandom();
    xfer  = req && rdy;
    redir = jp || br;
    tgt   = (br ? bt : jt) & 32'hFFFF_FFFC;
    if (redir) begin
      if (buffered) begin
        e = exp_q.pop_back();
        buffered = 1'b0;
      end
      if (xfer) stale = 1'b0;
      else if (req && !stale) begin
        stale = 1'b1;
        stale_addr = addr;
      end
      model_pc = tgt;
    end else if (xfer && stale) begin
      stale = 1'b0;
    end else if (xfer) begin
      exp_q.push_back({st ? 32'hFFFF_FFFF : cyc + 32'd1, model_pc, mem_word(model_pc)});
      model_pc = model_pc + 32'd4;
      buffered = st;
    end else if (buffered && !st) begin
      e = exp_q[exp_q.size() - 1];
      e[95:64] = cyc + 32'd1;
      exp_q[exp_q.size() - 1] = e;
      buffered = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(posedge Clk);
    #1;
    Rst_n = 1'b0; Stall = 1'b0; Jump = 1'b0; BrTaken = 1'b0; IM_Ready = 1'b0;
    #1;
    check("rst_im_req", {31'h0, IM_Req}, 32'h0);
    check("rst_valid", {31'h0, IFout_Valid}, 32'h0);
    check("rst_fields", IFout_PC | IFout_PC4 | IFout_Inst, 32'h0);
    exp_q.delete();
    model_pc = RESET_PC; buffered = 1'b0; stale = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    Rst_n = 1'b1;
    #1;
    check("rel_im_req", {31'h0, IM_Req}, 32'h0);
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic        p_st, p_redir, p_rst, h_valid;
    logic [31:0] h_pc, h_pc4, h_inst;
    logic [95:0] e;
    p_st = 1'b0; p_redir = 1'b0; p_rst = 1'b1;
    h_valid = 1'b0; h_pc = 32'h0; h_pc4 = 32'h0; h_inst = 32'h0;
    forever begin
      @(negedge Clk);
      if (!Rst_n) begin
        check("reset_valid", {31'h0, IFout_Valid}, 32'h0);
        check("reset_fields", IFout_PC | IFout_PC4 | IFout_Inst, 32'h0);
        p_rst = 1'b1;
      end else begin
        if (p_rst || p_redir) begin
          check("bubble_valid", {31'h0, IFout_Valid}, 32'h0);
        end else if (p_st) begin
          check("hold_valid", {31'h0, IFout_Valid}, {31'h0, h_valid});
          check("hold_pc", IFout_PC, h_pc);
          check("hold_pc4", IFout_PC4, h_pc4);
          check("hold_inst", IFout_Inst, h_inst);
        end else begin
          while (exp_q.size() > 0) begin
            e = exp_q[0];
            if (e[95:64] >= cyc) break;
            e = exp_q.pop_front();
            check("missed_delivery_pc", 32'hFFFF_FFFF, e[63:32]);
          end
          e = (exp_q.size() > 0) ? exp_q[0] : 96'h0;
          if (exp_q.size() > 0 && e[95:64] == cyc) begin
            e = exp_q.pop_front();
            check("deliver_valid", {31'h0, IFout_Valid}, 32'h1);
            check("deliver_pc", IFout_PC, e[63:32]);
            check("deliver_pc4", IFout_PC4, e[63:32] + 32'd4);
            check("deliver_inst", IFout_Inst, e[31:0]);
          end else begin
            check("idle_valid", {31'h0, IFout_Valid}, 32'h0);
          end
        end
        if (!IFout_Valid) check("bubble_fields", IFout_PC | IFout_PC4 | IFout_Inst, 32'h0);
        p_st = Stall; p_redir = Jump || BrTaken; p_rst = 1'b0;
      end
      h_valid = IFout_Valid; h_pc = IFout_PC; h_pc4 = IFout_PC4; h_inst = IFout_Inst;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    do_reset();
    // streaming: Ready held at 1
    repeat (12) step(0, 0, 0, 0, 0, 1);
    // Ready delayed 3 cycles per fetch
    repeat (4) begin
      repeat (3) step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1);
    end
    // stall coinciding with Ready at PC=8
    do_reset();
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0, 1);
    // branch + jump + stall together
    step(1, 1, 32'h200, 1, 32'h100, 1);
    repeat (3) step(0, 0, 0, 0, 0, 1);
    // jump to 0x40 while waiting on 0x10
    do_reset();
    repeat (4) step(0, 0, 0, 0, 0, 1);
    step(0, 1, 32'h40, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    repeat (3) step(0, 0, 0, 0, 0, 1);
    // reset mid-wait, then PC wrap
    step(0, 0, 0, 0, 0, 0);
    do_reset();
    step(0, 0, 0, 0, 0, 1);
    step(0, 1, 32'hFFFF_FFFE, 0, 0, 1);
    repeat (3) step(0, 0, 0, 0, 0, 1);
    // randomized traffic with occasional mid-run resets
    for (int i = 0; i < 3000; i++) begin
      if (i % 750 == 749) do_reset();
      else step($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 6, $urandom(),
                $urandom_range(0, 99) < 5, $urandom(), $urandom_range(0, 99) < 55);
    end
    // drain: no stall, no new fetches
    repeat (3) step(0, 0, 0, 0, 0, 0);
    @(negedge Clk);
    #1;
    check("queue_empty", exp_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/stage_if.md
# stage_if

Instruction Fetch stage of the pipelined CPU, including the IF/ID pipeline register. It owns the PC and fetches from a variable-latency instruction memory over a request/ready handshake. It feeds `IFout_PC`, `IFout_PC4` and `IFout_Inst` directly into the Instruction Decode stage. It also accepts stall from hazard logic and redirects from jump (ID) and taken branch (EX).

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value after reset.
- `Clk`  in  1: clock; all state updates on the rising edge.
- `Rst_n`  in  1: reset, asynchronous, active-low.
- `Stall`  in  1: hold PC and IF/ID (load-use hazard).
- `Jump`  in  1: jump redirect from ID.
- `Jtarg`  in  32: jump target.
- `BrTaken`  in  1: taken-branch redirect from EX.
- `Btarg`  in  32: branch target.
- `IM_Req`  out  1: fetch request.
- `IM_Addr`  out  32: fetch address; word-aligned.
- `IM_Ready`  in  1: `IM_Data` valid this cycle, completes the request.
- `IM_Data`  in  32: fetched instruction.
- `IFout_PC`  out  32: PC of the instruction in IF/ID.
- `IFout_PC4`  out  32: `IFout_PC` + 4, modulo 2^32.
- `IFout_Inst`  out  32: instruction; 32'h0 (NOP) when invalid.
- `IFout_Valid`  out  1: IF/ID holds a real instruction.

## Operation
**Handshake**
- A transfer completes in any cycle with `IM_Req` && `IM_Ready`.
- Once `IM_Req` rises, `IM_Req` and `IM_Addr` stay stable until `IM_Ready`.

**Redirect**
- Redirect = `BrTaken` || `Jump`.
- Target is `Btarg` when `BrTaken` is set, else `Jtarg`. Branch wins because it is the older instruction.
- Redirect has priority over `Stall`.
- Redirect loads PC with the target and loads IF/ID with a bubble: Valid=0, Inst=0, PC/PC4 = 0.

**FSM**
- S_REQ:
  - `IM_Req`=1, `IM_Addr`=PC.
  - Ready, no redirect, no Stall: IF/ID <= {PC, PC+4, IM_Data, 1}; PC <= PC+4; stay in S_REQ.
  - Ready with Stall: capture {PC, IM_Data} into the hold buffer; IF/ID unchanged; go to S_HOLD.
  - Not ready, no Stall: IF/ID <= bubble.
  - Not ready, Stall: IF/ID unchanged.
  - Redirect with Ready: data discarded; PC <= target; stay in S_REQ.
  - Redirect without Ready: PC <= target; go to S_DROP.
- S_HOLD:
  - `IM_Req`=0.
  - Stall=1: IF/ID and buffer hold.
  - Stall=0: IF/ID <= buffer contents (Valid=1); PC <= PC+4; go to S_REQ.
  - Redirect: buffer discarded; PC <= target; go to S_REQ.
- S_DROP:
  - `IM_Req`=1; `IM_Addr` = the stale address, held in an internal register.
  - On Ready: data discarded; go to S_REQ. PC already holds the target.
  - A further redirect here updates PC only.
  - IF/ID is a bubble unless Stall=1.

**Arithmetic**
- PC wraps 32'hFFFF_FFFC -> 32'h0000_0000.
- Bits [1:0] of targets are ignored; PC[1:0] is always 0.

## Timing
- Reset values:
  - PC = `RESET_PC`; state = S_REQ.
  - `IM_Req`=0 while `Rst_n`=0; `IM_Req`=1 from the first edge after release.
  - All `IFout_*` = 0.
- Fetch latency: an instruction is visible on `IFout_*` the cycle after the Ready edge.
- Throughput: one instruction per cycle when `IM_Ready` is held at 1 and there is no stall.
- Redirect penalty:
  - Fetch of the target starts the next cycle from S_REQ.
  - From S_DROP, the target fetch starts the cycle after the stale Ready.
- `Rst_n` asserted mid-request clears state immediately. The pending memory response is then ignored, because `IM_Req` drops.

## Configuration
- `STAGE_IF_PERF_EN` defined:
  - Adds output `Perf_Fetch` (32): counts Ready transfers whose data enters IF/ID or the hold buffer.
  - Adds output `Perf_Bubble` (32): counts cycles in which IF/ID is loaded with a bubble.
  - Both counters are reset to 0 and wrap.
- Undefined: the ports and counters are absent; all other behaviour is identical.

## Test plan
- `IM_Ready` held at 1, no hazards, RESET_PC=0 -> `IFout_PC` = 0, 4, 8, … on consecutive cycles, with `IFout_Inst` = the memory word at that address.
- Ready delayed 3 cycles per fetch -> `IFout_Valid` = 0 for 3 cycles, then 1 for one cycle; `IM_Addr` stable throughout each wait.
- Stall=1 for 2 cycles coinciding with Ready at PC=8:
  - IF/ID holds the PC=4 instruction, then shows PC=8 the cycle after Stall drops.
  - No instruction lost or duplicated.
- `BrTaken`=1, `Btarg`=0x100 together with `Jump`=1, `Jtarg`=0x200 and `Stall`=1 -> IF/ID becomes a bubble; the next `IM_Addr` is 0x100.
- `Jump` to 0x40 while waiting on PC=0x10 -> `IM_Addr` stays 0x10 until Ready; that data never appears on `IFout`; then `IM_Addr` = 0x40.
- `Rst_n` pulsed low mid-wait, plus wrap check -> all outputs 0 asynchronously and fetch restarts at `RESET_PC`; with PC=0xFFFF_FFFC, `IFout_PC4` = 0 and the next `IM_Addr` = 0.
